// File: rtl/trata_excecao.sv
// rtl/trata_excecao.sv - exception handler: latches EPC and cause, fetches the handler vector byte, loads the PC
module trata_excecao #(
  parameter int          MEM_LATENCIA = 2,
  parameter logic [31:0] PC_OFFSET    = 32'd4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        opInvalido,
  input  logic        overflow,
  input  logic        divZero,
  input  logic [31:0] pcAtual,
  input  logic [7:0]  memByte,
  output logic [1:0]  controle,
  output logic        memRead,
  output logic [31:0] epc,
  output logic [31:0] pcNovo,
  output logic        pcWrite,
  output logic        ocupado
);

  typedef enum logic [1:0] {
    OCIOSO     = 2'b00,
    LER_MEM    = 2'b01,
    CARREGA_PC = 2'b10
  } estado_t;

  // Counter starts at MEM_LATENCIA-1 so LER_MEM lasts exactly MEM_LATENCIA cycles.
  localparam logic [3:0] CONT_INICIAL = 4'(MEM_LATENCIA - 1);

  estado_t     estado_q, estado_d;
  logic [3:0]  cont_q, cont_d;
  logic [1:0]  controle_q, controle_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] pc_novo_q, pc_novo_d;

  // Next-state logic: requests are only sampled while idle; later ones are dropped.
  always_comb begin
    estado_d   = estado_q;
    cont_d     = cont_q;
    controle_d = controle_q;
    epc_d      = epc_q;
    pc_novo_d  = pc_novo_q;
    case (estado_q)
      OCIOSO: begin
        if (opInvalido || overflow || divZero) begin
          if (opInvalido) begin
            controle_d = 2'b00;
          end else if (overflow) begin
            controle_d = 2'b01;
          end else begin
            controle_d = 2'b10;
          end
          epc_d    = pcAtual - PC_OFFSET;
          cont_d   = CONT_INICIAL;
          estado_d = LER_MEM;
        end
      end
      LER_MEM: begin
        if (cont_q == 4'd0) begin
          pc_novo_d = {24'b0, memByte};
          estado_d  = CARREGA_PC;
        end else begin
          cont_d = cont_q - 4'd1;
        end
      end
      CARREGA_PC: begin
        estado_d = OCIOSO;
      end
      default: begin
        estado_d = OCIOSO;
      end
    endcase
  end

  // State and held outputs; reset aborts any fetch in progress.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q   <= OCIOSO;
      cont_q     <= 4'd0;
      controle_q <= 2'b00;
      epc_q      <= 32'd0;
      pc_novo_q  <= 32'd0;
    end else begin
      estado_q   <= estado_d;
      cont_q     <= cont_d;
      controle_q <= controle_d;
      epc_q      <= epc_d;
      pc_novo_q  <= pc_novo_d;
    end
  end

  // Strobes decode the registered state only, so no input reaches them combinationally.
  assign memRead  = (estado_q == LER_MEM);
  assign pcWrite  = (estado_q == CARREGA_PC);
  assign ocupado  = (estado_q != OCIOSO);
  assign controle = controle_q;
  assign epc      = epc_q;
  assign pcNovo   = pc_novo_q;

endmodule
